// File: rtl/pconv_accum_unit.sv
// Multiply-accumulate convolution unit: TAPS signed products summed, biased, shifted and clamped to one N-bit pixel.
// Optional build macro PCONV_RELU_EN selects ReLU clamping instead of signed saturation.
module pconv_accum_unit #(
  parameter int N             = 16,
  parameter int ACC_W         = 40,
  parameter int KERNEL_SIZE   = 3,
  parameter int INPUT_CHANNEL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [N-1:0]          input_din,
  input  logic [N-1:0]          weight_din,
  input  logic [ACC_W-1:0]      bias_din,
  input  logic [4:0]            shift_din,
  output logic [N-1:0]          conv_dout,
  output logic                  conv_dout_vld,
  input  logic                  conv_dout_rdy,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNEL+1)-1:0] tap_cnt
);

  localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE * INPUT_CHANNEL;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic signed [ACC_W:0] MAX_V = $signed({{(ACC_W + 2 - N){1'b0}}, {(N - 1){1'b1}}});
  localparam logic signed [ACC_W:0] MIN_V = $signed({{(ACC_W + 2 - N){1'b1}}, {(N - 1){1'b0}}});

  // Handshake: a pair moves on a clk edge where in_vld & in_rdy; a pixel moves
  // on an edge where conv_dout_vld & conv_dout_rdy. Valid never waits on ready.
  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

  state_t state, state_nxt;
  logic [1:0] drain_cnt;
  logic accept, last_tap, first_tap;

  logic signed [2*N-1:0] in_ext, w_ext, prod_q;
  logic prod_vld, prod_first;
  logic signed [ACC_W-1:0] prod_ext, acc, bias_q;
  logic [4:0] shift_q;
  logic signed [ACC_W:0] sum_q, r_val;
  logic [N-1:0] dout_nxt;

  assign in_rdy    = (state == ACCUM);
  assign accept    = in_vld & in_rdy;
  assign last_tap  = (tap_cnt == CNT_W'(TAPS - 1));
  assign first_tap = (tap_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_tap) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = OUTPUT;
      OUTPUT:  if (conv_dout_rdy) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      tap_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  assign in_ext   = {{N{input_din[N-1]}}, input_din};
  assign w_ext    = {{N{weight_din[N-1]}}, weight_din};
  assign prod_ext = {{(ACC_W - 2*N){prod_q[2*N-1]}}, prod_q};

  // Stage 1 registers the product; stage 2 folds it into the accumulator,
  // restarting the sum on the product that came from tap 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q     <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      acc        <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
    end else begin
      prod_vld   <= accept;
      prod_first <= accept & first_tap;
      if (accept) prod_q <= in_ext * w_ext;
      if (accept && first_tap) begin
        bias_q  <= bias_din;
        shift_q <= shift_din;
      end
      if (prod_vld) acc <= prod_first ? prod_ext : acc + prod_ext;
    end
  end

  // The bias add is one bit wider than the accumulator so it cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= '0;
    else if (state == DRAIN && drain_cnt == 2'd1)
      sum_q <= {acc[ACC_W-1], acc} + {bias_q[ACC_W-1], bias_q};
  end

  always_comb begin
    r_val    = sum_q >>> shift_q;
    dout_nxt = r_val[N-1:0];
    if (r_val > MAX_V) dout_nxt = MAX_V[N-1:0];
`ifdef PCONV_RELU_EN
    else if (r_val < 0) dout_nxt = '0;
`else
    else if (r_val < MIN_V) dout_nxt = MIN_V[N-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_dout     <= '0;
      conv_dout_vld <= 1'b0;
    end else if (state == DRAIN && drain_cnt == 2'd2) begin
      conv_dout     <= dout_nxt;
      conv_dout_vld <= 1'b1;
    end else if (state == OUTPUT && conv_dout_rdy) begin
      conv_dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pconv_accum_unit.sv
// Self-checking bench for pconv_accum_unit: directed pixels plus randomized pixels
// against a plain-arithmetic reference, checked by a monitor popping an expected queue.
module tb_pconv_accum_unit;

  localparam int N = 16;
  localparam int ACC_W = 40;
  localparam int TAPS = 9;

  logic clk, rst_n;
  logic in_vld, in_rdy;
  logic [N-1:0] input_din, weight_din;
  logic [ACC_W-1:0] bias_din;
  logic [4:0] shift_din;
  logic [N-1:0] conv_dout;
  logic conv_dout_vld, conv_dout_rdy;
  logic [3:0] tap_cnt;

  int total = 0;
  int bad = 0;
  logic [N-1:0] exp_q[$];
  int px_a[TAPS];
  int px_w[TAPS];
  bit rand_done;

  pconv_accum_unit #(.N(N), .ACC_W(ACC_W), .KERNEL_SIZE(3), .INPUT_CHANNEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .input_din(input_din), .weight_din(weight_din), .bias_din(bias_din),
    .shift_din(shift_din), .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
    .conv_dout_rdy(conv_dout_rdy), .tap_cnt(tap_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: exact integer sum, floor division by 2^shift, then clamp.
  function automatic logic [N-1:0] model(input longint bias, input int sh);
    longint s, d, q, hi, lo;
    s = bias;
    for (int i = 0; i < TAPS; i++) s += longint'(px_a[i]) * longint'(px_w[i]);
    d = longint'(1) << sh;
    if (s >= 0) q = s / d;
    else q = -((-s + d - 1) / d);
    hi = 32767;
`ifdef PCONV_RELU_EN
    lo = 0;
`else
    lo = -32768;
`endif
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return N'(q);
  endfunction

  // driver
  task automatic drive_tap(input int a, input int w, input longint b, input int sh);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_rdy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      total++;
      bad++;
      $display("FAIL tap_accept actual=in_rdy_low required=in_rdy_high within 200 cycles");
      return;
    end
    in_vld = 1'b1;
    input_din = N'(a);
    weight_din = N'(w);
    bias_din = ACC_W'(b);
    shift_din = 5'(sh);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send_pixel(input longint b, input int sh, input bit gap);
    exp_q.push_back(model(b, sh));
    for (int i = 0; i < TAPS; i++) begin
      drive_tap(px_a[i], px_w[i], b, sh);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic fill(input int a, input int w);
    for (int i = 0; i < TAPS; i++) begin
      px_a[i] = a;
      px_w[i] = w;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (rst_n && conv_dout_vld && conv_dout_rdy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected actual=%h required=no_output", conv_dout);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (conv_dout !== e) begin
          bad++;
          $display("FAIL out_pixel actual=%h required=%h", conv_dout, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_vld = 1'b0;
    input_din = '0;
    weight_din = '0;
    bias_din = '0;
    shift_din = '0;
    conv_dout_rdy = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_vld", conv_dout_vld, 0);
    check("reset_dout", conv_dout, 0);
    check("reset_tap_cnt", tap_cnt, 0);
    check("reset_in_rdy", in_rdy, 1);

    // 1: back-to-back, exact latency and one-cycle valid
    fill(2, 3);
    send_pixel(0, 0, 0);
    check("t1_in_rdy_drain", in_rdy, 0);
    check("t1_tap_cnt_wrap", tap_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_vld_edge%0d", k), conv_dout_vld, (k == 3) ? 1 : 0);
    end
    check("t1_dout", conv_dout, 54);
    @(posedge clk);
    #1;
    check("t1_vld_drop", conv_dout_vld, 0);
    check("t1_in_rdy_back", in_rdy, 1);
    wait_drain("t1_drain");

    // 2..4: sign, bias/shift, saturation
    fill(-4, 5);
    send_pixel(0, 0, 0);
    wait_drain("t2_drain");
    fill(256, 256);
    send_pixel(65536, 8, 0);
    wait_drain("t3_drain");
    fill(32767, 32767);
    send_pixel(0, 0, 0);
    wait_drain("t4a_drain");
    fill(-32768, 32767);
    send_pixel(0, 0, 0);
    wait_drain("t4b_drain");

    // 5: backpressure, then gapped input
    conv_dout_rdy = 1'b0;
    fill(2, 3);
    send_pixel(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_vld", conv_dout_vld, 1);
      check("t5_hold_dout", conv_dout, 54);
      check("t5_hold_in_rdy", in_rdy, 0);
      @(posedge clk);
      #1;
    end
    conv_dout_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t5_vld_drop", conv_dout_vld, 0);
    check("t5_in_rdy_back", in_rdy, 1);
    check("t5_drained", exp_q.size(), 0);
    for (int i = 0; i < TAPS; i++) begin
      px_a[i] = int'($urandom_range(0, 200)) - 100;
      px_w[i] = int'($urandom_range(0, 200)) - 100;
    end
    exp_q.push_back(model(1000, 2));
    for (int i = 0; i < TAPS; i++) begin
      drive_tap(px_a[i], px_w[i], 1000, 2);
      check("t5_tap_cnt_step", tap_cnt, (i + 1) % TAPS);
      if (i < TAPS - 1) begin
        @(posedge clk);
        #1;
        check("t5_tap_cnt_gap", tap_cnt, i + 1);
      end
    end
    wait_drain("t5_drain");

    // 6: reset mid-pixel discards the partial sum
    fill(100, 100);
    for (int i = 0; i < 4; i++) drive_tap(100, 100, 0, 0);
    check("t6_tap_cnt_partial", tap_cnt, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_vld", conv_dout_vld, 0);
    check("t6_tap_cnt", tap_cnt, 0);
    check("t6_in_rdy", in_rdy, 1);
    fill(1, 1);
    send_pixel(0, 0, 0);
    wait_drain("t6_drain");

    // randomized pixels with random downstream stalls
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          longint b;
          int sh;
          for (int i = 0; i < TAPS; i++) begin
            px_a[i] = int'($signed(16'($urandom_range(0, 65535))));
            px_w[i] = int'($signed(16'($urandom_range(0, 65535))));
          end
          b = longint'($signed($urandom)) * 64;
          sh = (p % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(14, 26));
          send_pixel(b, sh, $urandom_range(0, 3) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          conv_dout_rdy = ($urandom_range(0, 2) != 0);
        end
      end
    join
    conv_dout_rdy = 1'b1;
    wait_drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
